// File: rtl/led_mon_pkg.sv
// Shared definitions for the LED activity monitor: default widths and the
// layout of a queued event word {duration, led value}.
package led_mon_pkg;

    localparam int unsigned LED_W_DEF   = 4;
    localparam int unsigned DUR_W_DEF   = 16;

    // The LED value always sits at bit 0; the duration follows it.
    localparam int unsigned EVT_LED_LSB = 0;
    localparam int unsigned EVT_DUR_LSB = LED_W_DEF;
    localparam int unsigned EVT_W       = LED_W_DEF + DUR_W_DEF;

    // Field offset and total width for non-default bus/counter widths.
    function automatic int unsigned evt_dur_lsb(input int unsigned led_w);
        return EVT_LED_LSB + led_w;
    endfunction

    function automatic int unsigned evt_width(input int unsigned led_w,
                                              input int unsigned dur_w);
        return led_w + dur_w;
    endfunction

endpackage

// File: rtl/led_activity_monitor_if.sv
// Event port of the LED activity monitor: valid/ready handshake carrying
// the previously held LED value and how many cycles it was held.
interface led_activity_monitor_if #(
    parameter int unsigned LED_W = 4,
    parameter int unsigned DUR_W = 16
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [LED_W-1:0] evt_led;
    logic [DUR_W-1:0] evt_dur;

    modport master (
        output evt_valid,
        output evt_led,
        output evt_dur,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_led,
        input  evt_dur,
        output evt_ready
    );
endinterface

// File: rtl/led_activity_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so that
// full/empty fall out of a plain compare. A push against a full queue is
// dropped (and flagged) unless a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Status flags, effective push/pop qualification and show-ahead read.
    always_comb begin
        o_empty   = (r_wr_ptr == r_rd_ptr);
        o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_do_pop  = i_pop && !o_empty;
        w_do_push = i_push && (!o_full || w_do_pop);
        o_drop    = i_push && o_full && !w_do_pop;
        o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    end

    // Pointer advance and storage write; reset also zeroes the storage so
    // the show-ahead output reads 0 straight after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_activity_monitor.sv
// LED activity monitor: synchronises and debounces an asynchronous LED bus
// and queues one {previous value, cycles held} event per stable change.
module led_activity_monitor
    import led_mon_pkg::*;
#(
    parameter int unsigned LED_W         = LED_W_DEF,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DUR_W         = DUR_W_DEF,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LED_W-1:0]      led_in,
    led_activity_monitor_if.master evt,
    output logic                  overflow,
    input  logic                  ovf_clr
);
    localparam int unsigned EW      = evt_width(LED_W, DUR_W);
    localparam int unsigned DUR_LSB = evt_dur_lsb(LED_W);
    localparam int unsigned SW      = $clog2(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

    logic [LED_W-1:0] r_sync1;
    logic [LED_W-1:0] r_sync2;
    logic [LED_W-1:0] r_candidate;
    logic [LED_W-1:0] r_committed;
    logic [SW-1:0]    r_stab_cnt;
    logic [DUR_W-1:0] r_dur;

    logic             w_commit;
    logic [EW-1:0]    w_evt_wr;
    logic [EW-1:0]    w_evt_rd;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_pop;

    // Commit detection and event packing for the queue.
    always_comb begin
        w_commit = (r_sync2 == r_candidate) && (r_stab_cnt == STAB_MAX) &&
                   (r_candidate != r_committed);
        w_evt_wr = '0;
        w_evt_wr[EVT_LED_LSB +: LED_W] = r_committed;
        w_evt_wr[DUR_LSB +: DUR_W]     = r_dur;
        w_pop    = evt.evt_valid && evt.evt_ready;
    end

    // Synchroniser, debounce and saturating hold-duration counter. The
    // counter runs from 0 during reset, so the first edge out of reset
    // lands on 1 exactly as if a commit had happened there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_candidate <= '0;
            r_committed <= '0;
            r_stab_cnt  <= '0;
            r_dur       <= '0;
        end else begin
            r_sync1 <= led_in;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_candidate) begin
                r_candidate <= r_sync2;
                r_stab_cnt  <= '0;
            end else if (r_stab_cnt != STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end else if (w_commit) begin
                r_committed <= r_candidate;
            end
            if (w_commit) begin
                r_dur <= DUR_W'(1);
            end else if (r_dur != '1) begin
                r_dur <= r_dur + 1'b1;
            end
        end
    end

    // Sticky drop flag; a drop on the same edge beats a clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_commit),
        .i_wr_data (w_evt_wr),
        .i_pop     (w_pop),
        .o_rd_data (w_evt_rd),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_drop    (w_drop)
    );

    // Event port driven straight from the queue head.
    always_comb begin
        evt.evt_valid = !w_empty;
        evt.evt_led   = w_evt_rd[EVT_LED_LSB +: LED_W];
        evt.evt_dur   = w_evt_rd[DUR_LSB +: DUR_W];
    end

endmodule

// File: tb/tb_led_activity_monitor.sv
module tb_led_activity_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] led_in = '0;
    logic       ovf_a, ovf_b;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;
    int         checks = 0;
    int         errors = 0;

    led_activity_monitor_if #(.LED_W(4), .DUR_W(16)) ifa ();
    led_activity_monitor_if #(.LED_W(4), .DUR_W(8))  ifb ();

    led_activity_monitor #(.LED_W(4), .STABLE_CYCLES(4), .DUR_W(16), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .led_in(led_in), .evt(ifa.master),
        .overflow(ovf_a), .ovf_clr(clr_a));

    led_activity_monitor #(.LED_W(4), .STABLE_CYCLES(4), .DUR_W(8), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .led_in(led_in), .evt(ifb.master),
        .overflow(ovf_b), .ovf_clr(clr_b));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge R (first edge with reset low).
    task automatic do_reset();
        reset = 1'b1;
        led_in = '0;
        ifa.evt_ready = 1'b0;
        ifb.evt_ready = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic pop_a();
        ifa.evt_ready = 1'b1;
        tick(1);
        ifa.evt_ready = 1'b0;
    endtask

    // Values 1..n, 20 cycles apart, the first set just after R.
    task automatic drive_steps(input int n);
        for (int i = 1; i <= n; i++) begin
            led_in = 4'(i);
            if (i < n) tick(20);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ifa.evt_valid !== 1'b0 || ovf_a !== 1'b0 || ifa.evt_led !== 4'h0 || ifa.evt_dur !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b o=%b led=%h dur=%0d want 0 0 0 0",
                     ifa.evt_valid, ovf_a, ifa.evt_led, ifa.evt_dur);
        end
        for (int i = 0; i < 200; i++) begin
            tick(1);
            checks++;
            if (ifa.evt_valid !== 1'b0 || ovf_a !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d got v=%b o=%b want 0 0", i, ifa.evt_valid, ovf_a);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        tick(99);
        led_in = 4'h5;
        tick(6);
        checks++;
        if (ifa.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got %b want 0", ifa.evt_valid);
        end
        tick(1);
        checks++;
        if (ifa.evt_valid !== 1'b1 || ifa.evt_led !== 4'h0 || ifa.evt_dur !== 16'd106) begin
            errors++;
            $display("FAIL first_event got v=%b led=%h dur=%0d want 1 0 106",
                     ifa.evt_valid, ifa.evt_led, ifa.evt_dur);
        end
        pop_a();
        checks++;
        if (ifa.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_pop got v=%b want 0", ifa.evt_valid);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        tick(10);
        led_in = 4'h3;
        tick(2);
        led_in = 4'h0;
        tick(20);
        checks++;
        if (ifa.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_event got v=%b want 0", ifa.evt_valid);
        end
        led_in = 4'h3;
        tick(6);
        led_in = 4'h0;
        checks++;
        if (ifa.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_commit got v=%b want 0", ifa.evt_valid);
        end
        tick(1);
        checks++;
        if (ifa.evt_valid !== 1'b1 || ifa.evt_led !== 4'h0 || ifa.evt_dur !== 16'd39) begin
            errors++;
            $display("FAIL six_cycle_event got v=%b led=%h dur=%0d want 1 0 39",
                     ifa.evt_valid, ifa.evt_led, ifa.evt_dur);
        end
        pop_a();
        checks++;
        if (ifa.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_pop got v=%b want 0", ifa.evt_valid);
        end
        tick(5);
        checks++;
        if (ifa.evt_valid !== 1'b1 || ifa.evt_led !== 4'h3 || ifa.evt_dur !== 16'd6) begin
            errors++;
            $display("FAIL return_event got v=%b led=%h dur=%0d want 1 3 6",
                     ifa.evt_valid, ifa.evt_led, ifa.evt_dur);
        end
    endtask

    task automatic test_overflow();
        logic [3:0]  exp_led [4] = '{4'h0, 4'h1, 4'h2, 4'h3};
        logic [15:0] exp_dur [4] = '{16'd7, 16'd20, 16'd20, 16'd20};
        do_reset();
        drive_steps(5);
        tick(6);
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before_drop got %b want 0", ovf_a);
        end
        tick(1);
        checks++;
        if (ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL ovf_on_drop got %b want 1", ovf_a);
        end
        tick(13);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ifa.evt_valid !== 1'b1 || ifa.evt_led !== exp_led[i] || ifa.evt_dur !== exp_dur[i]) begin
                errors++;
                $display("FAIL drain%0d got v=%b led=%h dur=%0d want 1 %h %0d",
                         i, ifa.evt_valid, ifa.evt_led, ifa.evt_dur, exp_led[i], exp_dur[i]);
            end
            pop_a();
        end
        checks++;
        if (ifa.evt_valid !== 1'b0 || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL drained got v=%b o=%b want 0 1", ifa.evt_valid, ovf_a);
        end
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", ovf_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_led [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        do_reset();
        drive_steps(5);
        tick(6);
        checks++;
        if (ifa.evt_valid !== 1'b1 || ifa.evt_led !== 4'h0 || ifa.evt_dur !== 16'd7) begin
            errors++;
            $display("FAIL full_head got v=%b led=%h dur=%0d want 1 0 7",
                     ifa.evt_valid, ifa.evt_led, ifa.evt_dur);
        end
        pop_a();
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overflow got %b want 0", ovf_a);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ifa.evt_valid !== 1'b1 || ifa.evt_led !== exp_led[i] || ifa.evt_dur !== 16'd20) begin
                errors++;
                $display("FAIL b2b_drain%0d got v=%b led=%h dur=%0d want 1 %h 20",
                         i, ifa.evt_valid, ifa.evt_led, ifa.evt_dur, exp_led[i]);
            end
            pop_a();
        end
        checks++;
        if (ifa.evt_valid !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got v=%b o=%b want 0 0", ifa.evt_valid, ovf_a);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        led_in = 4'h1;
        tick(7);
        checks++;
        if (ifb.evt_valid !== 1'b1 || ifb.evt_led !== 4'h0 || ifb.evt_dur !== 8'd7) begin
            errors++;
            $display("FAIL sat_first got v=%b led=%h dur=%0d want 1 0 7",
                     ifb.evt_valid, ifb.evt_led, ifb.evt_dur);
        end
        ifb.evt_ready = 1'b1;
        tick(1);
        ifb.evt_ready = 1'b0;
        tick(302);
        led_in = 4'h2;
        tick(7);
        checks++;
        if (ifb.evt_valid !== 1'b1 || ifb.evt_led !== 4'h1 || ifb.evt_dur !== 8'd255) begin
            errors++;
            $display("FAIL saturate got v=%b led=%h dur=%0d want 1 1 255",
                     ifb.evt_valid, ifb.evt_led, ifb.evt_dur);
        end
        led_in = 4'h3;
        tick(7);
        reset = 1'b1;
        led_in = 4'h0;
        tick(1);
        checks++;
        if (ifb.evt_valid !== 1'b0 || ovf_b !== 1'b0 || ifb.evt_led !== 4'h0 || ifb.evt_dur !== 8'd0) begin
            errors++;
            $display("FAIL midop_reset got v=%b o=%b led=%h dur=%0d want 0 0 0 0",
                     ifb.evt_valid, ovf_b, ifb.evt_led, ifb.evt_dur);
        end
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if (ifb.evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle%0d got v=%b want 0", i, ifb.evt_valid);
            end
        end
        led_in = 4'h6;
        tick(7);
        checks++;
        if (ifb.evt_valid !== 1'b1 || ifb.evt_led !== 4'h0 || ifb.evt_dur !== 8'd27) begin
            errors++;
            $display("FAIL post_reset_event got v=%b led=%h dur=%0d want 1 0 27",
                     ifb.evt_valid, ifb.evt_led, ifb.evt_dur);
        end
    endtask

    initial begin
        ifa.evt_ready = 1'b0;
        ifb.evt_ready = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_saturate_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
